// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - eight-digit 7-segment scan controller with blanking and per-frame snapshot
module seg_scan_controller #(
  parameter int CLK_FREQ     = 100000000,
  parameter int SCAN_FREQ    = 500,
  parameter int TICK_DIV     = CLK_FREQ / SCAN_FREQ,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  input  logic        hold,
  output logic [7:0]  anode,
  output logic [6:0]  cathode,
  output logic        dp,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);

  // Counter only ever holds values below TICK_DIV (blank and drive phases are both shorter).
  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(TICK_DIV - BLANK_CYCLES - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_digit_idx;
  logic [31:0]      r_snapshot;
  logic [7:0]       r_dpsnap;
  logic             r_frame_start;
  logic [7:0]       r_anode;
  logic [6:0]       r_cathode;
  logic             r_dp;
  logic             r_frame_done;

  logic [2:0]  w_next_idx;
  logic [2:0]  w_drive_idx;
  logic        w_any_en;
  logic        w_wrap;
  logic [31:0] w_snap_src;
  logic [7:0]  w_dp_src;
  logic [3:0]  w_drive_nib;
  logic [7:0]  w_drive_onehot;
  logic [7:0]  w_cur_onehot;

  // Active-low segment pattern {a..g} for one hex nibble.
  function automatic logic [6:0] hexdec(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  // First enabled index strictly after cur, searched cyclically; returns cur when it is the only one.
  function automatic logic [2:0] next_after(input logic [2:0] cur, input logic [7:0] mask);
    logic [2:0] res;
    logic [2:0] cand;
    res = cur;
    for (int k = 7; k >= 1; k--) begin
      cand = cur + 3'(k);
      if (mask[cand]) res = cand;
    end
    return res;
  endfunction

  assign w_any_en       = |digit_en;
  assign w_next_idx     = next_after(r_digit_idx, digit_en);
  assign w_wrap         = (w_next_idx <= r_digit_idx);
  // The mask may have changed since the index was chosen, so re-resolve it when driving starts.
  assign w_drive_idx    = digit_en[r_digit_idx] ? r_digit_idx : w_next_idx;
  // A pending frame start means the snapshot is taken on this very edge, so decode the live inputs.
  assign w_snap_src     = r_frame_start ? data_in : r_snapshot;
  assign w_dp_src       = r_frame_start ? dp_in : r_dpsnap;
  assign w_drive_nib    = w_snap_src[{w_drive_idx, 2'b00} +: 4];
  assign w_drive_onehot = 8'b1 << w_drive_idx;
  assign w_cur_onehot   = 8'b1 << r_digit_idx;

  // Scan FSM: blank gap, then drive one digit, then pick the next enabled digit.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state       <= ST_BLANK;
      r_cnt         <= '0;
      r_digit_idx   <= 3'd0;
      r_snapshot    <= 32'h0;
      r_dpsnap      <= 8'h0;
      r_frame_start <= 1'b1;
      r_anode       <= 8'hFF;
      r_cathode     <= 7'h7F;
      r_dp          <= 1'b1;
      r_frame_done  <= 1'b0;
    end else if (hold) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_state == ST_BLANK) begin
        r_anode   <= 8'hFF;
        r_cathode <= 7'h7F;
        r_dp      <= 1'b1;
        if (!w_any_en) begin
          // Idle: nothing to show; the next enabled digit starts a fresh frame.
          r_cnt         <= '0;
          r_digit_idx   <= 3'd0;
          r_frame_start <= 1'b1;
        end else if (r_cnt == BLANK_LAST) begin
          r_state     <= ST_DRIVE;
          r_cnt       <= '0;
          r_digit_idx <= w_drive_idx;
          r_anode     <= ~w_drive_onehot;
          r_cathode   <= hexdec(w_drive_nib);
          r_dp        <= ~w_dp_src[w_drive_idx];
          if (r_frame_start) begin
            r_snapshot    <= data_in;
            r_dpsnap      <= dp_in;
            r_frame_start <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        if (r_cnt == DRIVE_LAST) begin
          r_state   <= ST_BLANK;
          r_cnt     <= '0;
          r_anode   <= 8'hFF;
          r_cathode <= 7'h7F;
          r_dp      <= 1'b1;
          if (w_any_en) begin
            r_digit_idx <= w_next_idx;
            if (w_wrap) begin
              r_frame_done  <= 1'b1;
              r_frame_start <= 1'b1;
            end
          end else begin
            r_digit_idx   <= 3'd0;
            r_frame_start <= 1'b1;
          end
        end else begin
          r_cnt   <= r_cnt + 1'b1;
          // A digit disabled mid-slot goes dark at once; the slot still runs to its end.
          r_anode <= digit_en[r_digit_idx] ? ~w_cur_onehot : 8'hFF;
        end
      end
    end
  end

  assign anode      = r_anode;
  assign cathode    = r_cathode;
  assign dp         = r_dp;
  assign digit_idx  = r_digit_idx;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - self-checking bench for seg_scan_controller
module tb_seg_scan_controller;

  localparam int TD = 10;
  localparam int BC = 2;

  logic        clk_in;
  logic        reset;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic        hold;
  logic [7:0]  anode;
  logic [6:0]  cathode;
  logic        dp;
  logic [2:0]  digit_idx;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Slot-level reference: ordered list of enabled digits, position in it, phase within the slot.
  int          mdl_list[$];
  int          mdl_pos;
  int          mdl_ph;
  logic        mdl_fd;
  logic [31:0] mdl_data;
  logic [7:0]  mdl_dpv;

  seg_scan_controller #(
    .CLK_FREQ(100000000),
    .SCAN_FREQ(500),
    .TICK_DIV(TD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .data_in(data_in),
    .dp_in(dp_in),
    .digit_en(digit_en),
    .hold(hold),
    .anode(anode),
    .cathode(cathode),
    .dp(dp),
    .digit_idx(digit_idx),
    .frame_done(frame_done)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic mdl_start(input logic [7:0] mask);
    mdl_list.delete();
    for (int i = 0; i < 8; i++) if (mask[i]) mdl_list.push_back(i);
    mdl_pos = 0;
    mdl_ph  = 0;
    mdl_fd  = 1'b0;
  endtask

  task automatic mdl_advance();
    mdl_ph++;
    mdl_fd = 1'b0;
    if (mdl_ph == TD) begin
      mdl_ph  = 0;
      mdl_fd  = (mdl_pos == mdl_list.size() - 1);
      mdl_pos = (mdl_pos + 1) % mdl_list.size();
    end
  endtask

  task automatic mdl_eval(output logic [7:0] ea, output logic [6:0] ec, output logic ed,
                          output logic ef, output logic [2:0] ei);
    int d;
    d  = mdl_list[mdl_pos];
    ei = 3'(d);
    ef = hold ? 1'b0 : mdl_fd;
    if (mdl_ph == BC && mdl_pos == 0) begin
      mdl_data = data_in;
      mdl_dpv  = dp_in;
    end
    if (mdl_ph < BC) begin
      ea = 8'hFF; ec = 7'h7F; ed = 1'b1;
    end else begin
      ea = ~(8'h01 << d);
      ec = hex7(mdl_data[4*d +: 4]);
      ed = ~mdl_dpv[d];
    end
  endtask

  task automatic do_reset(input logic [7:0] mask, input logic [31:0] d, input logic [7:0] dpv);
    @(negedge clk_in);
    reset = 1'b1; hold = 1'b0; digit_en = mask; data_in = d; dp_in = dpv;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    mdl_start(mask);
  endtask

  task automatic test_reset();
    reset = 1'b1; hold = 1'b0; digit_en = 8'hFF; data_in = $urandom; dp_in = 8'hFF;
    repeat (3) @(negedge clk_in);
    n_tests++; if (anode !== 8'hFF) begin n_fail++; $display("FAIL reset_anode got %h exp ff", anode); end
    n_tests++; if (cathode !== 7'h7F) begin n_fail++; $display("FAIL reset_cathode got %h exp 7f", cathode); end
    n_tests++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got %b exp 1", dp); end
    n_tests++; if (digit_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got %0d exp 0", digit_idx); end
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b exp 0", frame_done); end
  endtask

  task automatic test_first_slot();
    logic [7:0] ea; logic [6:0] ec; logic ed, ef; logic [2:0] ei;
    do_reset(8'hFF, 32'h76543210, 8'h00);
    for (int k = 0; k < 24; k++) begin
      if (k > 0) begin @(negedge clk_in); if (!hold) mdl_advance(); end
      mdl_eval(ea, ec, ed, ef, ei);
      n_tests++;
      if ({anode, cathode, dp, frame_done} !== {ea, ec, ed, ef}) begin
        n_fail++;
        $display("FAIL first_slot k=%0d got a=%h c=%b dp=%b fd=%b exp a=%h c=%b dp=%b fd=%b",
                 k, anode, cathode, dp, frame_done, ea, ec, ed, ef);
      end
      if (mdl_ph >= BC) begin
        n_tests++;
        if (digit_idx !== ei) begin n_fail++; $display("FAIL first_slot_idx k=%0d got %0d exp %0d", k, digit_idx, ei); end
      end
    end
  endtask

  task automatic test_frame_wrap();
    logic [7:0] ea; logic [6:0] ec; logic ed, ef; logic [2:0] ei;
    int nfd;
    nfd = 0;
    do_reset(8'hFF, 32'h76543210, 8'h00);
    for (int k = 0; k < 170; k++) begin
      if (k > 0) begin @(negedge clk_in); if (!hold) mdl_advance(); end
      mdl_eval(ea, ec, ed, ef, ei);
      if (frame_done === 1'b1) nfd++;
      n_tests++;
      if ({anode, cathode, dp, frame_done} !== {ea, ec, ed, ef}) begin
        n_fail++;
        $display("FAIL frame_wrap k=%0d got a=%h c=%b dp=%b fd=%b exp a=%h c=%b dp=%b fd=%b",
                 k, anode, cathode, dp, frame_done, ea, ec, ed, ef);
      end
      if (k == 40 + BC || k == 80 + BC || k == 90 + BC) begin
        ec = (k == 40 + BC) ? 7'b1001100 : (k == 80 + BC) ? 7'b0111000 : 7'b0110000;
        n_tests++;
        if (cathode !== ec) begin n_fail++; $display("FAIL frame_wrap_seg k=%0d got %b exp %b", k, cathode, ec); end
      end
      if (mdl_pos == 3 && mdl_ph == BC + 1) data_in = 32'h89ABCDEF;
    end
    n_tests++;
    if (nfd != 2) begin n_fail++; $display("FAIL frame_wrap_count got %0d exp 2", nfd); end
  endtask

  task automatic test_mask_random();
    logic [7:0] ea; logic [6:0] ec; logic ed, ef; logic [2:0] ei;
    logic [7:0] mask;
    int ncyc;
    for (int it = 0; it < 6; it++) begin
      mask = (it == 0) ? 8'b1000_0010 : 8'($urandom_range(1, 255));
      do_reset(mask, $urandom, 8'($urandom));
      ncyc = mdl_list.size() * TD * 2 + TD;
      for (int k = 0; k < ncyc; k++) begin
        if (k > 0) begin @(negedge clk_in); if (!hold) mdl_advance(); end
        mdl_eval(ea, ec, ed, ef, ei);
        n_tests++;
        if ({anode, cathode, dp, frame_done} !== {ea, ec, ed, ef}) begin
          n_fail++;
          $display("FAIL mask_%h k=%0d got a=%h c=%b dp=%b fd=%b exp a=%h c=%b dp=%b fd=%b",
                   mask, k, anode, cathode, dp, frame_done, ea, ec, ed, ef);
        end
        if (mdl_ph >= BC) begin
          n_tests++;
          if (digit_idx !== ei) begin n_fail++; $display("FAIL mask_idx_%h k=%0d got %0d exp %0d", mask, k, digit_idx, ei); end
        end
        if ($urandom_range(0, 7) == 0) data_in = $urandom;
        if ($urandom_range(0, 7) == 0) dp_in = 8'($urandom);
      end
    end
  endtask

  task automatic test_empty_mask();
    logic [7:0] ea; logic [6:0] ec; logic ed, ef; logic [2:0] ei;
    do_reset(8'hFF, $urandom, 8'h00);
    for (int k = 0; k < BC + 4; k++) begin
      if (k > 0) begin @(negedge clk_in); if (!hold) mdl_advance(); end
      mdl_eval(ea, ec, ed, ef, ei);
      n_tests++;
      if ({anode, cathode, dp, frame_done} !== {ea, ec, ed, ef}) begin
        n_fail++;
        $display("FAIL empty_pre k=%0d got a=%h c=%b fd=%b exp a=%h c=%b fd=%b", k, anode, cathode, frame_done, ea, ec, ef);
      end
    end
    digit_en = 8'h00;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_in);
      n_tests++;
      if ({anode, frame_done} !== {8'hFF, 1'b0}) begin
        n_fail++;
        $display("FAIL empty_idle k=%0d got a=%h fd=%b exp a=ff fd=0", k, anode, frame_done);
      end
    end
    digit_en = 8'h04;
    mdl_start(8'h04);
    for (int k = 0; k < 35; k++) begin
      if (k > 0) begin @(negedge clk_in); if (!hold) mdl_advance(); end
      mdl_eval(ea, ec, ed, ef, ei);
      n_tests++;
      if ({anode, cathode, dp, frame_done} !== {ea, ec, ed, ef}) begin
        n_fail++;
        $display("FAIL empty_recover k=%0d got a=%h c=%b dp=%b fd=%b exp a=%h c=%b dp=%b fd=%b",
                 k, anode, cathode, dp, frame_done, ea, ec, ed, ef);
      end
    end
  endtask

  task automatic test_hold_reset();
    logic [7:0] ea; logic [6:0] ec; logic ed, ef; logic [2:0] ei;
    int nfe;
    nfe = 0;
    do_reset(8'hFF, $urandom, 8'($urandom));
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin @(negedge clk_in); if (!hold) mdl_advance(); end
      mdl_eval(ea, ec, ed, ef, ei);
      if (anode === 8'hFE) nfe++;
      n_tests++;
      if ({anode, cathode, dp, frame_done} !== {ea, ec, ed, ef}) begin
        n_fail++;
        $display("FAIL hold k=%0d got a=%h c=%b dp=%b fd=%b exp a=%h c=%b dp=%b fd=%b",
                 k, anode, cathode, dp, frame_done, ea, ec, ed, ef);
      end
      if (k == BC + 3) hold = 1'b1;
      if (k == BC + 8) hold = 1'b0;
    end
    n_tests++;
    if (nfe != TD - BC + 5) begin n_fail++; $display("FAIL hold_slot_len got %0d exp %0d", nfe, TD - BC + 5); end
    hold = 1'b1; reset = 1'b1;
    @(negedge clk_in);
    n_tests++;
    if ({anode, cathode, dp, digit_idx, frame_done} !== {8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_reset got a=%h c=%h dp=%b idx=%0d fd=%b exp a=ff c=7f dp=1 idx=0 fd=0",
               anode, cathode, dp, digit_idx, frame_done);
    end
    hold = 1'b0;
  endtask

  task automatic test_dp();
    logic [7:0] ea; logic [6:0] ec; logic ed, ef; logic [2:0] ei;
    int ndp;
    ndp = 0;
    do_reset(8'h01, $urandom, 8'h01);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin @(negedge clk_in); if (!hold) mdl_advance(); end
      mdl_eval(ea, ec, ed, ef, ei);
      if (dp === 1'b0) ndp++;
      n_tests++;
      if ({anode, cathode, dp, frame_done} !== {ea, ec, ed, ef}) begin
        n_fail++;
        $display("FAIL dp k=%0d got a=%h c=%b dp=%b fd=%b exp a=%h c=%b dp=%b fd=%b",
                 k, anode, cathode, dp, frame_done, ea, ec, ed, ef);
      end
    end
    n_tests++;
    if (ndp != 4 * (TD - BC)) begin n_fail++; $display("FAIL dp_count got %0d exp %0d", ndp, 4 * (TD - BC)); end
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; digit_en = 8'hFF; data_in = 32'h0; dp_in = 8'h0;
    test_reset();
    test_first_slot();
    test_frame_wrap();
    test_mask_random();
    test_empty_mask();
    test_hold_reset();
    test_dp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
